// File: rtl/dbus_arbiter.sv
// Two-requester round-robin arbiter driving a pipelined AHB-Lite master port.
// One data phase outstanding at a time; completions are routed back to the issuing requester.
module dbus_arbiter #(
  parameter int AW = 32,
  parameter int DW = 32
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          m0_req,
  input  logic          m0_write,
  input  logic [2:0]    m0_size,
  input  logic [AW-1:0] m0_addr,
  input  logic [DW-1:0] m0_wdata,
  output logic          m0_gnt,
  output logic          m0_rsp_vld,
  output logic          m0_rsp_err,
  output logic [DW-1:0] m0_rdata,
  input  logic          m1_req,
  input  logic          m1_write,
  input  logic [2:0]    m1_size,
  input  logic [AW-1:0] m1_addr,
  input  logic [DW-1:0] m1_wdata,
  output logic          m1_gnt,
  output logic          m1_rsp_vld,
  output logic          m1_rsp_err,
  output logic [DW-1:0] m1_rdata,
  output logic          dbus_hwrite,
  output logic [2:0]    dbus_hsize,
  output logic [2:0]    dbus_hburst,
  output logic [3:0]    dbus_hport,
  output logic [1:0]    dbus_htrans,
  output logic          dbus_hmastlock,
  output logic [AW-1:0] dbus_haddr,
  output logic [DW-1:0] dbus_hwdata,
  input  logic          dbus_hready,
  input  logic          dbus_hresp,
  input  logic [DW-1:0] dbus_hrdata
);

  typedef enum logic {M0 = 1'b0, M1 = 1'b1} req_id_t;

  req_id_t       lg;
  req_id_t       dp_owner;
  req_id_t       sel;
  logic          dp_vld;
  logic [DW-1:0] hwdata_q;
  logic          blocked;
  logic          issue;
  logic          accept;
  logic          complete;

  always_comb begin
    sel = M0;
    if (m0_req && m1_req)
      sel = (lg == M0) ? M1 : M0;
    else if (m1_req)
      sel = M1;
  end

  // First cycle of an ERROR response must be followed by IDLE on the address bus.
  assign blocked  = dbus_hresp && !dbus_hready;
  assign issue    = (m0_req || m1_req) && !blocked && !rst;
  assign accept   = issue && dbus_hready;
  assign complete = dp_vld && dbus_hready && !rst;

  assign m0_gnt = accept && (sel == M0);
  assign m1_gnt = accept && (sel == M1);

  always_comb begin
    dbus_htrans = 2'b00;
    dbus_hwrite = 1'b0;
    dbus_hsize  = 3'b010;
    dbus_haddr  = '0;
    if (issue) begin
      dbus_htrans = 2'b10;
      dbus_hwrite = (sel == M1) ? m1_write : m0_write;
      dbus_hsize  = (sel == M1) ? m1_size  : m0_size;
      dbus_haddr  = (sel == M1) ? m1_addr  : m0_addr;
    end
  end

  assign dbus_hburst    = 3'b000;
  assign dbus_hmastlock = 1'b0;
  assign dbus_hport     = 4'b0001;
  assign dbus_hwdata    = hwdata_q;

  assign m0_rsp_vld = complete && (dp_owner == M0);
  assign m1_rsp_vld = complete && (dp_owner == M1);
  assign m0_rsp_err = m0_rsp_vld && dbus_hresp;
  assign m1_rsp_err = m1_rsp_vld && dbus_hresp;
  assign m0_rdata   = m0_rsp_vld ? dbus_hrdata : '0;
  assign m1_rdata   = m1_rsp_vld ? dbus_hrdata : '0;

  // lg resets to M1 so that m0 wins the first tie; a wait state freezes everything.
  always_ff @(posedge clk) begin
    if (rst) begin
      dp_vld   <= 1'b0;
      dp_owner <= M0;
      lg       <= M1;
      hwdata_q <= '0;
    end else if (dbus_hready) begin
      if (accept) begin
        dp_vld   <= 1'b1;
        dp_owner <= sel;
        lg       <= sel;
        hwdata_q <= (sel == M1) ? m1_wdata : m0_wdata;
      end else begin
        dp_vld <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_dbus_arbiter.sv
// Randomized bench for dbus_arbiter: requester agents and an AHB slave agent feed a
// transaction-level model (round-robin pick plus a queue of outstanding data phases).
module tb_dbus_arbiter;
  localparam int AW = 32;
  localparam int DW = 32;

  logic          clk = 1'b0;
  logic          rst;
  logic          m0_req, m0_write, m0_gnt, m0_rsp_vld, m0_rsp_err;
  logic [2:0]    m0_size;
  logic [AW-1:0] m0_addr;
  logic [DW-1:0] m0_wdata, m0_rdata;
  logic          m1_req, m1_write, m1_gnt, m1_rsp_vld, m1_rsp_err;
  logic [2:0]    m1_size;
  logic [AW-1:0] m1_addr;
  logic [DW-1:0] m1_wdata, m1_rdata;
  logic          dbus_hwrite, dbus_hmastlock, dbus_hready, dbus_hresp;
  logic [2:0]    dbus_hsize, dbus_hburst;
  logic [3:0]    dbus_hport;
  logic [1:0]    dbus_htrans;
  logic [AW-1:0] dbus_haddr;
  logic [DW-1:0] dbus_hwdata, dbus_hrdata;

  dbus_arbiter #(.AW(AW), .DW(DW)) dut (
    .clk(clk), .rst(rst),
    .m0_req(m0_req), .m0_write(m0_write), .m0_size(m0_size), .m0_addr(m0_addr),
    .m0_wdata(m0_wdata), .m0_gnt(m0_gnt), .m0_rsp_vld(m0_rsp_vld),
    .m0_rsp_err(m0_rsp_err), .m0_rdata(m0_rdata),
    .m1_req(m1_req), .m1_write(m1_write), .m1_size(m1_size), .m1_addr(m1_addr),
    .m1_wdata(m1_wdata), .m1_gnt(m1_gnt), .m1_rsp_vld(m1_rsp_vld),
    .m1_rsp_err(m1_rsp_err), .m1_rdata(m1_rdata),
    .dbus_hwrite(dbus_hwrite), .dbus_hsize(dbus_hsize), .dbus_hburst(dbus_hburst),
    .dbus_hport(dbus_hport), .dbus_htrans(dbus_htrans), .dbus_hmastlock(dbus_hmastlock),
    .dbus_haddr(dbus_haddr), .dbus_hwdata(dbus_hwdata), .dbus_hready(dbus_hready),
    .dbus_hresp(dbus_hresp), .dbus_hrdata(dbus_hrdata)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic          write;
    logic [2:0]    size;
    logic [AW-1:0] addr;
    logic [DW-1:0] wdata;
  } xfer_t;

  xfer_t         pend [2];
  bit            pend_v [2];
  int            owner_q [$];
  int            last_granted;
  logic [DW-1:0] last_wdata;
  int            waits_left, is_err, err_stage;
  int            mode, rst_armed, grant_count;
  bit            e_gnt [2];
  int            checks = 0;
  int            errors = 0;

  task automatic checkOutput(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    if (obs !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, obs, exp, $time);
    end
  endtask

  task automatic startDataPhase();
    err_stage = 0;
    if (mode == 0) begin
      waits_left = 0;
      is_err     = 0;
    end else begin
      waits_left = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 2)) : 0;
      is_err     = ($urandom_range(0, 9) == 0) ? 1 : 0;
    end
  endtask

  task automatic applyStimulus(input int cyc);
    int rate;
    @(negedge clk);
    rate = (mode == 0) ? 100 : 45;
    for (int x = 0; x < 2; x++) begin
      if (!pend_v[x] && int'($urandom_range(0, 99)) < rate) begin
        pend[x].write = 1'($urandom_range(0, 1));
        pend[x].size  = 3'($urandom_range(0, 7));
        pend[x].addr  = $urandom;
        pend[x].wdata = $urandom;
        pend_v[x]     = 1'b1;
      end
    end
    m0_req = pend_v[0]; m0_write = pend[0].write; m0_size = pend[0].size;
    m0_addr = pend[0].addr; m0_wdata = pend[0].wdata;
    m1_req = pend_v[1]; m1_write = pend[1].write; m1_size = pend[1].size;
    m1_addr = pend[1].addr; m1_wdata = pend[1].wdata;
    dbus_hrdata = $urandom;
    if (owner_q.size() == 0) begin
      dbus_hready = 1'b1; dbus_hresp = 1'b0;
    end else if (waits_left > 0) begin
      dbus_hready = 1'b0; dbus_hresp = 1'b0;
    end else if (is_err != 0 && err_stage == 0) begin
      dbus_hready = 1'b0; dbus_hresp = 1'b1;
    end else begin
      dbus_hready = 1'b1; dbus_hresp = (is_err != 0);
    end
    if (cyc % 400 == 0) rst_armed = 1;
    rst = 1'b0;
    if (cyc < 2) rst = 1'b1;
    else if (mode == 1 && rst_armed != 0 && owner_q.size() > 0 && waits_left > 0) begin
      rst = 1'b1;
      rst_armed = 0;
    end
  endtask

  task automatic checkCycle();
    bit   any, blocked, nonseq, completing;
    int   sel, own;
    logic [DW-1:0] exp_rd [2];
    e_gnt[0] = 1'b0;
    e_gnt[1] = 1'b0;
    if (rst) begin
      checkOutput("rst_handshake", {60'd0, m1_gnt, m0_gnt, m1_rsp_vld, m0_rsp_vld}, 64'd0);
      return;
    end
    any     = m0_req || m1_req;
    blocked = dbus_hresp && !dbus_hready;
    if (m0_req && m1_req) sel = 1 - last_granted;
    else sel = m1_req ? 1 : 0;
    nonseq = any && !blocked;
    e_gnt[sel] = nonseq && dbus_hready;
    completing = owner_q.size() > 0 && dbus_hready;
    own = completing ? owner_q[0] : 0;
    exp_rd[0] = '0;
    exp_rd[1] = '0;
    if (completing) exp_rd[own] = dbus_hrdata;

    checkOutput("htrans", 64'(dbus_htrans), nonseq ? 64'd2 : 64'd0);
    checkOutput("haddr",  64'(dbus_haddr),  nonseq ? 64'(pend[sel].addr) : 64'd0);
    checkOutput("hwrite", 64'(dbus_hwrite), nonseq ? 64'(pend[sel].write) : 64'd0);
    checkOutput("hsize",  64'(dbus_hsize),  nonseq ? 64'(pend[sel].size) : 64'd2);
    checkOutput("handshake", {60'd0, m1_gnt, m0_gnt, m1_rsp_vld, m0_rsp_vld},
                {60'd0, e_gnt[1], e_gnt[0], completing && own == 1, completing && own == 0});
    if (completing)
      checkOutput("rsp_err", 64'(own == 1 ? m1_rsp_err : m0_rsp_err), 64'(dbus_hresp));
    checkOutput("m0_rdata", 64'(m0_rdata), 64'(exp_rd[0]));
    checkOutput("m1_rdata", 64'(m1_rdata), 64'(exp_rd[1]));
    checkOutput("hwdata", 64'(dbus_hwdata), 64'(last_wdata));
    checkOutput("consts", {56'd0, dbus_hburst, dbus_hport, dbus_hmastlock}, {56'd0, 3'b000, 4'b0001, 1'b0});
    if (mode == 0 && any) begin
      checkOutput("rr_order", 64'(m1_gnt), 64'(grant_count % 2));
      grant_count++;
    end
  endtask

  task automatic updateModel();
    if (rst) begin
      owner_q.delete();
      last_granted = 1;
      last_wdata   = '0;
      waits_left   = 0;
      is_err       = 0;
      err_stage    = 0;
      return;
    end
    if (dbus_hready) begin
      if (owner_q.size() > 0) void'(owner_q.pop_front());
      for (int x = 0; x < 2; x++) begin
        if (e_gnt[x]) begin
          owner_q.push_back(x);
          last_granted = x;
          last_wdata   = pend[x].wdata;
          pend_v[x]    = 1'b0;
          startDataPhase();
        end
      end
    end else if (waits_left > 0) begin
      waits_left--;
    end else begin
      err_stage = 1;
    end
  endtask

  initial begin
    rst = 1'b1;
    pend_v[0] = 1'b0; pend_v[1] = 1'b0;
    pend[0] = '{1'b0, 3'd0, '0, '0};
    pend[1] = '{1'b0, 3'd0, '0, '0};
    last_granted = 1; last_wdata = '0;
    waits_left = 0; is_err = 0; err_stage = 0;
    rst_armed = 0; grant_count = 0;
    for (int i = 0; i < 3000; i++) begin
      mode = (i < 12) ? 0 : 1;
      applyStimulus(i);
      #1 checkCycle();
      @(posedge clk);
      updateModel();
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end
endmodule
